// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
// The FSM state encoding, slave word addresses and counter widths live here.
package sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  // Wide enough for the largest allowed retry limit (15).
  localparam int unsigned RETRY_W = 4;

  // The timer counts 0 .. timeout_cycles-1, so clog2 of the limit is enough.
  function automatic int unsigned timer_width(input int unsigned timeout_cycles);
    return (timeout_cycles < 32'd2) ? 32'd1 : $clog2(timeout_cycles);
  endfunction

endpackage

// File: rtl/sysid_txn_timer.sv
// Per-attempt timeout counter plus retry counter for the boot checker.
// expire pulses in the last cycle of an attempt; exhausted means no retries remain.
module sysid_txn_timer
  import sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  localparam int unsigned TW            = timer_width(TIMEOUT_CYCLES)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic active,
  input  logic restart,
  output logic expire,
  output logic exhausted
);

  logic [TW-1:0]      timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;

  assign expire    = active && (timer_q == TW'(TIMEOUT_CYCLES - 32'd1));
  assign exhausted = (retry_q >= RETRY_W'(MAX_RETRIES));

  // Next-count logic; restart has priority so a completing word never counts as a retry.
  always_comb begin
    timer_d = timer_q;
    retry_d = retry_q;
    if (restart || !active || expire) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
    if (restart) begin
      retry_d = '0;
    end else if (expire && !exhausted) begin
      retry_d = retry_q + RETRY_W'(1);
    end else begin
      retry_d = retry_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

endmodule

// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the system-ID and timestamp words after reset
// (or on start), compares them with build-time values and latches pass/done flags.
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0,
  parameter logic [31:0] EXPECTED_TS    = 32'h0,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_e      state_q, state_d;
  logic        auto_pending_q, auto_pending_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic tmr_active, tmr_restart, tmr_expire, tmr_exhausted, accepted;

  // Bus outputs decode straight from the state flop so reset drops avm_read at once.
  assign avm_read    = (state_q == ST_ID_REQ) || (state_q == ST_TS_REQ);
  assign avm_address = (state_q == ST_TS_REQ) ? ADDR_TS : ADDR_ID;
  assign tmr_active  = (state_q == ST_ID_REQ) || (state_q == ST_ID_WAIT) ||
                       (state_q == ST_TS_REQ) || (state_q == ST_TS_WAIT);
  assign accepted    = avm_read && !avm_waitrequest;

  assign busy        = tmr_active;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout_err = timeout_err_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

  sysid_txn_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES)
  ) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .active    (tmr_active),
    .restart   (tmr_restart),
    .expire    (tmr_expire),
    .exhausted (tmr_exhausted)
  );

  // Next-state, capture and compare logic.
  always_comb begin
    state_d        = state_q;
    auto_pending_d = auto_pending_q;
    done_d         = done_q;
    pass_d         = pass_q;
    id_match_d     = id_match_q;
    ts_match_d     = ts_match_q;
    timeout_err_d  = timeout_err_q;
    id_value_d     = id_value_q;
    ts_value_d     = ts_value_q;
    tmr_restart    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start || auto_pending_q) begin
          state_d        = ST_ID_REQ;
          auto_pending_d = 1'b0;
          done_d         = 1'b0;
          pass_d         = 1'b0;
          id_match_d     = 1'b0;
          ts_match_d     = 1'b0;
          timeout_err_d  = 1'b0;
          id_value_d     = 32'h0;
          ts_value_d     = 32'h0;
          tmr_restart    = 1'b1;
        end else if (state_q == ST_DONE) begin
          done_d = 1'b1;
          pass_d = !timeout_err_q && id_match_q && (ts_match_q || !CHECK_TS);
        end else begin
          state_d = ST_IDLE;
        end
      end
      // In REQ a timeout beats a late acceptance; the retry re-issues the same read.
      ST_ID_REQ, ST_TS_REQ: begin
        if (tmr_expire) begin
          if (tmr_exhausted) begin
            timeout_err_d = 1'b1;
            state_d       = ST_DONE;
          end else begin
            state_d = state_q;
          end
        end else if (accepted) begin
          state_d = (state_q == ST_ID_REQ) ? ST_ID_WAIT : ST_TS_WAIT;
        end else begin
          state_d = state_q;
        end
      end
      ST_ID_WAIT: begin
        if (avm_readdatavalid) begin
          id_value_d  = avm_readdata;
          id_match_d  = (avm_readdata == EXPECTED_ID);
          state_d     = ST_TS_REQ;
          tmr_restart = 1'b1;
        end else if (tmr_expire) begin
          if (tmr_exhausted) begin
            timeout_err_d = 1'b1;
            state_d       = ST_DONE;
          end else begin
            state_d = ST_ID_REQ;
          end
        end else begin
          state_d = ST_ID_WAIT;
        end
      end
      ST_TS_WAIT: begin
        if (avm_readdatavalid) begin
          ts_value_d = avm_readdata;
          ts_match_d = (avm_readdata == EXPECTED_TS);
          state_d    = ST_DONE;
        end else if (tmr_expire) begin
          if (tmr_exhausted) begin
            timeout_err_d = 1'b1;
            state_d       = ST_DONE;
          end else begin
            state_d = ST_TS_REQ;
          end
        end else begin
          state_d = ST_TS_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      auto_pending_q <= AUTO_START;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      id_match_q     <= 1'b0;
      ts_match_q     <= 1'b0;
      timeout_err_q  <= 1'b0;
      id_value_q     <= 32'h0;
      ts_value_q     <= 32'h0;
    end else begin
      state_q        <= state_d;
      auto_pending_q <= auto_pending_d;
      done_q         <= done_d;
      pass_q         <= pass_d;
      id_match_q     <= id_match_d;
      ts_match_q     <= ts_match_d;
      timeout_err_q  <= timeout_err_d;
      id_value_q     <= id_value_d;
      ts_value_q     <= ts_value_d;
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Self-checking bench for sysid_boot_checker: an Avalon slave model with per-address
// stall/latency knobs and a cycle-count reference model of the check sequence.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'h6722A572;
  localparam logic [31:0] EXP_TS = 32'h4C0FFEE0;
  localparam int T = 16;
  localparam int R = 2;
  localparam int BOUND = 400;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_address, avm_read, busy, done, pass, id_match, ts_match, timeout_err;
  logic [31:0] id_value, ts_value;
  logic [4:0]  flags;

  int          stall_cfg [2];
  int          dly_cfg   [2];
  bit          noresp_cfg[2];
  logic [31:0] data_cfg  [2];
  int          acc_cnt   [2];
  bit          inj_rdv = 1'b0;
  logic [31:0] inj_data = 32'h0;

  int n_cmp = 0;
  int n_err = 0;

  assign flags = {done, pass, id_match, ts_match, timeout_err};

  always #5 clock = ~clock;

  sysid_boot_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .CHECK_TS       (1'b1),
    .TIMEOUT_CYCLES (T),
    .MAX_RETRIES    (R),
    .AUTO_START     (1'b1)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .id_match          (id_match),
    .ts_match          (ts_match),
    .timeout_err       (timeout_err),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  // Slave: stalls each new read stall_cfg cycles, answers dly_cfg cycles after acceptance.
  initial begin : slave
    int stall_left;
    int resp_cnt;
    logic [31:0] resp_data;
    bit req_active;
    stall_left = 0; resp_cnt = 0; resp_data = 32'h0; req_active = 1'b0;
    forever begin
      @(posedge clock); #1;
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom();
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = resp_data;
        end
      end
      if (inj_rdv) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = inj_data;
      end
      if (avm_read) begin
        if (!req_active) begin
          req_active = 1'b1;
          stall_left = stall_cfg[avm_address];
        end
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avm_waitrequest = 1'b0;
          req_active = 1'b0;
          acc_cnt[avm_address]++;
          if (!noresp_cfg[avm_address]) begin
            resp_cnt = dly_cfg[avm_address];
            resp_data = data_cfg[avm_address];
          end
        end
      end else begin
        avm_waitrequest = 1'b0;
        req_active = 1'b0;
      end
    end
  end

  task automatic slave_defaults();
    for (int a = 0; a < 2; a++) begin
      stall_cfg[a] = 0; dly_cfg[a] = 1; noresp_cfg[a] = 1'b0;
    end
    data_cfg[0] = EXP_ID;
    data_cfg[1] = EXP_TS;
  endtask

  // Reference: a word completes iff stall + accept + latency fits in T cycles;
  // otherwise all R+1 attempts of T cycles burn and the check ends with a timeout.
  task automatic model(input int s0, input int d0, input int s1, input int d1,
                       input logic [31:0] idw, input logic [31:0] tsw,
                       output int n, output logic [4:0] f,
                       output logic [31:0] idv, output logic [31:0] tsv);
    logic idm, tsm, terr;
    idm = 1'b0; tsm = 1'b0; terr = 1'b0; idv = 32'h0; tsv = 32'h0;
    n = 2;
    if (s0 + 1 + d0 > T) begin
      n += (R + 1) * T; terr = 1'b1;
    end else begin
      n += s0 + 1 + d0; idv = idw; idm = (idw == EXP_ID);
      if (s1 + 1 + d1 > T) begin
        n += (R + 1) * T; terr = 1'b1;
      end else begin
        n += s1 + 1 + d1; tsv = tsw; tsm = (tsw == EXP_TS);
      end
    end
    f = {1'b1, !terr && idm && tsm, idm, tsm, terr};
  endtask

  // Pulse start and count edges until done (edge that samples start is n=1).
  task automatic run_start(output int n);
    @(negedge clock); start = 1'b1;
    n = 0;
    do begin
      @(posedge clock); #2;
      start = 1'b0;
      n++;
    end while (!done && n < BOUND);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #2;
    n_cmp++;
    if ({avm_read, avm_address, busy, flags, id_value, ts_value} !== 72'h0) begin
      $display("FAIL reset_outputs: got read=%b busy=%b flags=%b id=%h ts=%h, want all zero",
               avm_read, busy, flags, id_value, ts_value);
      n_err++;
    end
  endtask

  task automatic test_auto_start();
    int n;
    slave_defaults();
    @(negedge clock); reset_n = 1'b1;
    n = 0;
    do begin @(posedge clock); #2; n++; end while (!done && n < BOUND);
    n_cmp++;
    if (n !== 6) begin $display("FAIL auto_latency: got %0d edges, want 6", n); n_err++; end
    n_cmp++;
    if (flags !== 5'b11110) begin $display("FAIL auto_flags: got %b, want 11110", flags); n_err++; end
    n_cmp++;
    if ({id_value, ts_value} !== {EXP_ID, EXP_TS}) begin
      $display("FAIL auto_values: got %h/%h, want %h/%h", id_value, ts_value, EXP_ID, EXP_TS);
      n_err++;
    end
  endtask

  task automatic test_id_mismatch();
    int n;
    slave_defaults();
    data_cfg[0] = 32'h00000001;
    run_start(n);
    n_cmp++;
    if ({flags, id_value} !== {5'b10010, 32'h1}) begin
      $display("FAIL mismatch_flags: got %b id=%h, want 10010 id=00000001", flags, id_value);
      n_err++;
    end
    @(negedge clock); start = 1'b1;
    @(posedge clock); #2; start = 1'b0;
    n_cmp++;
    if ({busy, flags, id_value, ts_value} !== {1'b1, 69'h0}) begin
      $display("FAIL rerun_clear: got busy=%b flags=%b id=%h ts=%h, want busy=1 rest 0",
               busy, flags, id_value, ts_value);
      n_err++;
    end
    n = 1;
    do begin @(posedge clock); #2; n++; end while (!done && n < BOUND);
    n_cmp++;
    if (n !== 6) begin $display("FAIL rerun_latency: got %0d, want 6", n); n_err++; end
    n_cmp++;
    if ({flags, id_value, ts_value} !== {5'b10010, 32'h1, EXP_TS}) begin
      $display("FAIL rerun_result: got %b id=%h ts=%h, want 10010 id=00000001 ts=%h",
               flags, id_value, ts_value, EXP_TS);
      n_err++;
    end
  endtask

  task automatic stall_ts_case(input int stall, input string tag);
    int n, rd1, rises, acc0;
    bit cur, prev;
    slave_defaults();
    stall_cfg[1] = stall;
    acc0 = acc_cnt[1];
    rd1 = 0; rises = 0; prev = 1'b0;
    @(negedge clock); start = 1'b1;
    n = 0;
    do begin
      @(posedge clock); #2;
      start = 1'b0;
      n++;
      cur = avm_read && avm_address;
      if (cur) rd1++;
      if (cur && !prev) rises++;
      prev = cur;
    end while (!done && n < BOUND);
    n_cmp++;
    if (n !== stall + 6) begin $display("FAIL %s_latency: got %0d, want %0d", tag, n, stall + 6); n_err++; end
    n_cmp++;
    if (flags !== 5'b11110) begin $display("FAIL %s_flags: got %b, want 11110", tag, flags); n_err++; end
    n_cmp++;
    if ({rd1, rises, acc_cnt[1] - acc0} !== {stall + 1, 32'd1, 32'd1}) begin
      $display("FAIL %s_ts_read: got %0d cycles %0d rises %0d accepts, want %0d/1/1",
               tag, rd1, rises, acc_cnt[1] - acc0, stall + 1);
      n_err++;
    end
  endtask

  task automatic test_no_response();
    int n, rises0, rd1;
    bit cur, prev;
    slave_defaults();
    noresp_cfg[0] = 1'b1;
    rises0 = 0; rd1 = 0; prev = 1'b0;
    @(negedge clock); start = 1'b1;
    n = 0;
    do begin
      @(posedge clock); #2;
      start = 1'b0;
      n++;
      cur = avm_read && !avm_address;
      if (cur && !prev) rises0++;
      if (avm_read && avm_address) rd1++;
      prev = cur;
    end while (!done && n < BOUND);
    n_cmp++;
    if (n !== (R + 1) * T + 2) begin $display("FAIL noresp_latency: got %0d, want %0d", n, (R + 1) * T + 2); n_err++; end
    n_cmp++;
    if ({flags, id_value, ts_value} !== {5'b10001, 64'h0}) begin
      $display("FAIL noresp_flags: got %b id=%h ts=%h, want 10001 zeros", flags, id_value, ts_value);
      n_err++;
    end
    n_cmp++;
    if ({rises0, rd1} !== {R + 1, 32'd0}) begin
      $display("FAIL noresp_attempts: got %0d id attempts %0d ts cycles, want %0d/0", rises0, rd1, R + 1);
      n_err++;
    end
    repeat (2 * T) @(posedge clock);
  endtask

  task automatic test_stray_rdv();
    int n;
    logic [4:0] f0;
    slave_defaults();
    run_start(n);
    f0 = flags;
    @(negedge clock); inj_data = 32'hDEAD0000 | 32'($urandom_range(0, 65535)); inj_rdv = 1'b1;
    repeat (4) @(posedge clock);
    #2; inj_rdv = 1'b0;
    n_cmp++;
    if ({flags, f0, id_value, ts_value} !== {5'b11110, 5'b11110, EXP_ID, EXP_TS}) begin
      $display("FAIL stray_rdv: got flags=%b id=%h ts=%h, want 11110 %h %h", flags, id_value, ts_value, EXP_ID, EXP_TS);
      n_err++;
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    slave_defaults();
    stall_cfg[1] = 6;
    @(negedge clock); start = 1'b1;
    n = 0;
    do begin @(posedge clock); #2; start = 1'b0; n++; end while (!(avm_read && avm_address) && n < 50);
    n_cmp++;
    if ({avm_read, id_value} !== {1'b1, EXP_ID}) begin
      $display("FAIL midrun_pre: got read=%b id=%h, want 1 %h", avm_read, id_value, EXP_ID);
      n_err++;
    end
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({avm_read, avm_address, busy, flags, id_value, ts_value} !== 72'h0) begin
      $display("FAIL midrun_reset: got read=%b busy=%b flags=%b id=%h, want all zero", avm_read, busy, flags, id_value);
      n_err++;
    end
    repeat (3) @(posedge clock);
    stall_cfg[1] = 0;
    @(negedge clock); reset_n = 1'b1;
    n = 0;
    do begin @(posedge clock); #2; n++; end while (!done && n < BOUND);
    n_cmp++;
    if ({n, flags, id_value, ts_value} !== {32'd6, 5'b11110, EXP_ID, EXP_TS}) begin
      $display("FAIL midrun_rerun: got n=%0d flags=%b id=%h ts=%h, want 6 11110", n, flags, id_value, ts_value);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    int n, a0;
    slave_defaults();
    a0 = acc_cnt[0] + acc_cnt[1];
    @(negedge clock); start = 1'b1;
    n = 0;
    do begin
      @(posedge clock); #2;
      n++;
      start = (n >= 1 && n <= 3) ? 1'b1 : 1'b0;
      if (n == 1) start = 1'b0;
      if (n == 2) start = 1'b1;
    end while (!done && n < BOUND);
    start = 1'b0;
    n_cmp++;
    if (n !== 6) begin $display("FAIL busy_start_latency: got %0d, want 6", n); n_err++; end
    repeat (10) @(posedge clock);
    #2;
    n_cmp++;
    if ({flags, busy} !== {5'b11110, 1'b0}) begin $display("FAIL busy_start_flags: got %b busy=%b, want 11110 0", flags, busy); n_err++; end
    n_cmp++;
    if (acc_cnt[0] + acc_cnt[1] - a0 !== 2) begin
      $display("FAIL busy_start_reads: got %0d reads, want 2", acc_cnt[0] + acc_cnt[1] - a0);
      n_err++;
    end
  endtask

  task automatic test_random();
    int s0, d0, s1, d1, n, en;
    logic [31:0] idw, tsw, eid, ets;
    logic [4:0] ef;
    for (int it = 0; it < 12; it++) begin
      s0 = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, T - 3));
      s1 = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, T - 3));
      d0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T)) : int'($urandom_range(1, 3));
      d1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T)) : int'($urandom_range(1, 3));
      idw = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom();
      tsw = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom();
      slave_defaults();
      stall_cfg[0] = s0; stall_cfg[1] = s1; dly_cfg[0] = d0; dly_cfg[1] = d1;
      data_cfg[0] = idw; data_cfg[1] = tsw;
      model(s0, d0, s1, d1, idw, tsw, en, ef, eid, ets);
      run_start(n);
      n_cmp++;
      if (n !== en) begin
        $display("FAIL rand%0d_latency: got %0d, want %0d (s=%0d/%0d d=%0d/%0d)", it, n, en, s0, s1, d0, d1);
        n_err++;
      end
      n_cmp++;
      if ({flags, id_value, ts_value} !== {ef, eid, ets}) begin
        $display("FAIL rand%0d_result: got %b %h %h, want %b %h %h", it, flags, id_value, ts_value, ef, eid, ets);
        n_err++;
      end
      repeat (2 * T + 4) @(posedge clock);
    end
  endtask

  initial begin
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    slave_defaults();
    test_reset();
    test_auto_start();
    test_id_mismatch();
    stall_ts_case(10, "stall_ts");
    stall_ts_case(T - 2, "rdv_tie");
    test_no_response();
    test_stray_rdv();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
